// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART/ALU command sequencer.
//   - default operand and opcode widths
//   - ALU opcode encodings (also used by the ALU and the benches)
//   - sequencer state encoding
//   - op_supported(): opcode-valid decode
package uart_alu_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OP_W   = 8;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_NOR = 8'h27;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4
    } state_e;

    // Opcode is passed zero-extended so any OP_W up to 32 compares correctly.
    function automatic logic op_supported(input logic [31:0] op);
        case (op)
            {24'd0, OP_ADD}, {24'd0, OP_SUB}, {24'd0, OP_AND}, {24'd0, OP_OR},
            {24'd0, OP_XOR}, {24'd0, OP_SRA}, {24'd0, OP_SRL}, {24'd0, OP_NOR}:
                op_supported = 1'b1;
            default:
                op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_watchdog.sv
// Inter-byte watchdog for the command sequencer.
// Ports:
//   i_clk, i_reset : clock, async active-high reset
//   i_en           : count while high; counter held at zero when low
//   i_clr          : clear (a byte was popped); wins over expiry
//   o_expire       : combinational, high in the cycle the count hits LIMIT-1
//                    with no clear; the counter wraps to zero on that edge
module uart_alu_watchdog #(
    parameter int LIMIT = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_expire = i_en && !i_clr && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!i_en || i_clr || o_expire)
            cnt_d = '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Command sequencer between the UART RX/TX FIFOs and the ALU.
// Pops operand A, operand B and opcode from the RX FIFO, presents them to the
// ALU as registered values, captures the result one cycle later and pushes a
// single result byte (or ERR_CODE for an unknown opcode) to the TX FIFO.
// A watchdog drops a partial frame if the next byte is too slow to arrive.
// Ports:
//   i_clk, i_reset            : clock, async active-high reset
//   i_rx_empty, i_r_data      : RX FIFO status / head word
//   o_rd_uart                 : RX pop strobe
//   i_tx_full                 : TX FIFO full flag
//   o_wr_uart, o_w_data       : TX push strobe / word
//   o_alu_a, o_alu_b, o_alu_op: registered ALU inputs
//   i_alu_result              : combinational ALU result
//   o_err, o_timeout          : one-cycle event pulses
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int               DATA_W       = DEF_DATA_W,
    parameter int               OP_W         = DEF_OP_W,
    parameter int               TIMEOUT_CLKS = 1000000,
    parameter logic [DATA_W-1:0] ERR_CODE    = DATA_W'(8'hFF)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_empty,
    input  logic [DATA_W-1:0] i_r_data,
    output logic              o_rd_uart,
    input  logic              i_tx_full,
    output logic              o_wr_uart,
    output logic [DATA_W-1:0] o_w_data,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_err,
    output logic              o_timeout
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              err_q, err_d, to_q, to_d;

    logic in_wait, pop, push, wd_en, wd_expire;

    // Strobes are Mealy on the FIFO flags; gated by reset so nothing moves
    // while the block is held.
    assign in_wait = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_B) ||
                     (state_q == ST_WAIT_OP);
    assign pop     = in_wait && !i_rx_empty && !i_reset;
    assign push    = (state_q == ST_SEND) && !i_tx_full && !i_reset;
    assign wd_en   = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

    uart_alu_watchdog #(.LIMIT(TIMEOUT_CLKS)) u_wd (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_en     (wd_en),
        .i_clr    (pop),
        .o_expire (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (pop) begin
                    a_d     = i_r_data;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (pop) begin
                    b_d     = i_r_data;
                    state_d = ST_WAIT_OP;
                end else if (wd_expire) begin
                    // Held operands are left as-is; only the frame is dropped.
                    state_d = ST_WAIT_A;
                    to_d    = 1'b1;
                end
            end
            ST_WAIT_OP: begin
                if (pop) begin
                    op_d    = i_r_data[OP_W-1:0];
                    state_d = ST_EXEC;
                end else if (wd_expire) begin
                    state_d = ST_WAIT_A;
                    to_d    = 1'b1;
                end
            end
            ST_EXEC: begin
                // ALU has had a full cycle on the registered operands.
                if (op_supported(32'(op_q))) begin
                    res_d = i_alu_result;
                end else begin
                    res_d = ERR_CODE;
                    err_d = 1'b1;
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (push)
                    state_d = ST_WAIT_A;
            end
            default: state_d = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign o_rd_uart = pop;
    assign o_wr_uart = push;
    assign o_w_data  = res_q;
    assign o_alu_a   = a_q;
    assign o_alu_b   = b_q;
    assign o_alu_op  = op_q;
    assign o_err     = err_q;
    assign o_timeout = to_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;
    import uart_alu_ctrl_pkg::*;

    localparam int TO = 100;

    logic       i_clk = 1'b0;
    logic       i_reset, i_rx_empty, i_tx_full;
    logic [7:0] i_r_data, i_alu_result;
    logic       o_rd_uart, o_wr_uart, o_err, o_timeout;
    logic [7:0] o_w_data, o_alu_a, o_alu_b, o_alu_op;

    always #5 i_clk = ~i_clk;

    uart_alu_ctrl #(.DATA_W(8), .OP_W(8), .TIMEOUT_CLKS(TO), .ERR_CODE(8'hFF)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_empty(i_rx_empty), .i_r_data(i_r_data), .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result), .o_err(o_err), .o_timeout(o_timeout)
    );

    // Behavioural ALU: what the real ALU computes from its operands.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, b, op);
        case (op)
            OP_ADD:  alu_fn = a + b;
            OP_SUB:  alu_fn = a - b;
            OP_AND:  alu_fn = a & b;
            OP_OR:   alu_fn = a | b;
            OP_XOR:  alu_fn = a ^ b;
            OP_SRA:  alu_fn = 8'($signed(a) >>> b);
            OP_SRL:  alu_fn = a >> b;
            OP_NOR:  alu_fn = ~(a | b);
            default: alu_fn = 8'hA5;
        endcase
    endfunction

    function automatic bit is_sup(input logic [7:0] op);
        is_sup = (op == 8'h20) || (op == 8'h22) || (op == 8'h24) || (op == 8'h25) ||
                 (op == 8'h26) || (op == 8'h03) || (op == 8'h02) || (op == 8'h27);
    endfunction

    assign i_alu_result = alu_fn(o_alu_a, o_alu_b, o_alu_op);

    typedef struct {
        logic [7:0] a, b, op, res;
        bit         err;
    } frame_t;

    logic [7:0] rx_q[$];
    frame_t     exp_q[$];
    int n_checks = 0, n_errors = 0;
    int idx = 0, idle = 0, cyc = 0, op_edge = 0, stalls = 0;
    bit pending = 0, to_exp = 0, rand_full = 0;
    logic [7:0] fa = 0, fb = 0;
    int n_push = 0, n_push_exp = 0, n_err = 0, n_err_exp = 0, n_to = 0, n_to_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic upd_rx();
        i_rx_empty = (rx_q.size() == 0);
        i_r_data   = i_rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_q.push_back(b);
        upd_rx();
    endtask

    task automatic send_frame(input logic [7:0] a, b, op);
        send_byte(a); send_byte(b); send_byte(op);
    endtask

    // One clock: sample at negedge against the model, then advance the model
    // at the posedge using the observed handshakes.
    task automatic step();
        bit rd, wr, exp_rd, exp_wr, exp_err, in_send;
        logic [7:0] d;
        frame_t f;
        @(negedge i_clk);
        in_send = pending && (cyc >= op_edge + 1);
        exp_rd  = !pending && (rx_q.size() > 0);
        exp_wr  = in_send && !i_tx_full;
        exp_err = pending && (exp_q.size() > 0) && exp_q[0].err && (cyc == op_edge + 1);
        rd = o_rd_uart;
        wr = o_wr_uart;
        chk("rd", rd, exp_rd);
        chk("wr", wr, exp_wr);
        chk("err", o_err, exp_err);
        chk("timeout", o_timeout, to_exp);
        if (o_err) n_err++;
        if (o_timeout) n_to++;
        if (in_send && i_tx_full) stalls++;
        if (wr && exp_q.size() > 0) begin
            chk("wdata", o_w_data, exp_q[0].res);
            chk("alu_a", o_alu_a, exp_q[0].a);
            chk("alu_b", o_alu_b, exp_q[0].b);
            chk("alu_op", o_alu_op, exp_q[0].op);
            chk("latency", cyc + 1 - op_edge, 2 + stalls);
        end
        to_exp = 0;
        @(posedge i_clk);
        cyc++;
        #1;
        if (rd && rx_q.size() > 0) begin
            d    = rx_q.pop_front();
            idle = 0;
            if (idx == 0) begin
                fa = d; idx = 1;
            end else if (idx == 1) begin
                fb = d; idx = 2;
            end else begin
                f.a = fa; f.b = fb; f.op = d; f.err = !is_sup(d);
                f.res = f.err ? 8'hFF : alu_fn(fa, fb, d);
                exp_q.push_back(f);
                n_push_exp++;
                if (f.err) n_err_exp++;
                pending = 1; op_edge = cyc; stalls = 0; idx = 0;
            end
        end else if (idx > 0) begin
            idle++;
            if (idle == TO) begin
                idx = 0; idle = 0; to_exp = 1; n_to_exp++;
            end
        end
        if (wr) begin
            n_push++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            pending = 0;
        end
        upd_rx();
        if (rand_full) i_tx_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pending || idx != 0 || rx_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("drain_bound", 1, 0);
    endtask

    // Called #1 after a posedge.
    task automatic do_reset();
        i_reset = 1'b1;
        #1;
        chk("rst_alu_a", o_alu_a, 0);
        chk("rst_alu_b", o_alu_b, 0);
        chk("rst_alu_op", o_alu_op, 0);
        chk("rst_wdata", o_w_data, 0);
        chk("rst_rd", o_rd_uart, 0);
        chk("rst_wr", o_wr_uart, 0);
        chk("rst_err", o_err, 0);
        chk("rst_timeout", o_timeout, 0);
        @(posedge i_clk); @(posedge i_clk);
        cyc += 2;
        #1;
        i_reset = 1'b0;
        idx = 0; idle = 0; pending = 0; to_exp = 0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] op;
        int n;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
        i_reset = 1'b1; i_tx_full = 1'b0;
        upd_rx();
        @(posedge i_clk); #1;
        do_reset();

        // ADD
        send_frame(8'h05, 8'h03, 8'h20);
        wait_idle(50);
        // SUB then SRA back-to-back
        send_frame(8'h05, 8'h07, 8'h22);
        send_frame(8'hF0, 8'h02, 8'h03);
        wait_idle(50);
        // unsupported opcode, then a valid frame
        send_frame(8'h01, 8'h02, 8'h3F);
        send_frame(8'h09, 8'h04, 8'h26);
        wait_idle(50);
        // partial frame dropped by the watchdog, then AND
        send_byte(8'h11);
        wait_idle(4 * TO);
        send_frame(8'h0C, 8'h0A, 8'h24);
        wait_idle(50);
        // TX full for 50 cycles with the next frame's first byte queued
        i_tx_full = 1'b1;
        send_frame(8'h21, 8'h13, 8'h20);
        send_byte(8'h07);
        repeat (55) step();
        i_tx_full = 1'b0;
        send_byte(8'h08); send_byte(8'h27);
        wait_idle(50);
        // reset after operand B, then OR
        send_byte(8'h55); send_byte(8'h66);
        n = 0;
        while (idx != 2 && n < 20) begin step(); n++; end
        chk("reach_b", idx, 2);
        do_reset();
        send_frame(8'h03, 8'h04, 8'h25);
        wait_idle(50);

        // random traffic with random TX back-pressure and byte gaps
        rand_full = 1;
        for (int f = 0; f < 60; f++) begin
            op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
            send_byte(8'($urandom)); repeat ($urandom_range(0, 4)) step();
            send_byte(8'($urandom)); repeat ($urandom_range(0, 4)) step();
            send_byte(op);           repeat ($urandom_range(0, 4)) step();
        end
        rand_full = 0;
        i_tx_full = 1'b0;
        wait_idle(2000);

        chk("push_count", n_push, n_push_exp);
        chk("err_count", n_err, n_err_exp);
        chk("timeout_count", n_to, n_to_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Command sequencer between the UART core's RX/TX FIFOs and the ALU. Pops three bytes from the RX FIFO: operand A, operand B, then opcode. Drives the ALU with registered operands, captures the result and pushes one result byte into the TX FIFO. A watchdog drops partial frames so a lost byte cannot desynchronise the host link.

Parameters:
DATA_W, 8, width of operands, result and FIFO words
OP_W, 8, opcode width (opcode is taken from the low OP_W bits of the third byte)
TIMEOUT_CLKS, 1000000, clocks allowed between bytes of one frame before the frame is dropped (10 ms at 100 MHz)
ERR_CODE, 8'hFF, byte sent in place of the result for an unsupported opcode

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_rx_empty  in  1  RX FIFO empty flag
i_r_data  in  DATA_W  RX FIFO head word, valid while i_rx_empty=0
o_rd_uart  out  1  RX FIFO pop strobe, one cycle per byte
i_tx_full  in  1  TX FIFO full flag
o_wr_uart  out  1  TX FIFO push strobe, one cycle per result
o_w_data  out  DATA_W  TX FIFO write word
o_alu_a  out  DATA_W  registered operand A to the ALU
o_alu_b  out  DATA_W  registered operand B to the ALU
o_alu_op  out  OP_W  registered opcode to the ALU
i_alu_result  in  DATA_W  combinational ALU result
o_err  out  1  one-cycle pulse: unsupported opcode
o_timeout  out  1  one-cycle pulse: partial frame dropped

Behaviour:
- One clock; asynchronous active-high reset. Reset: state=WAIT_A; o_alu_a/b/op=0; result register=0; timeout counter=0; o_rd_uart, o_wr_uart, o_err and o_timeout are 0. o_w_data is 0 (it equals the result register).
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_x is Mealy: o_rd_uart = !i_rx_empty. On that same edge, i_r_data is latched into the A, B or opcode register and the FSM advances (A->B->OP->EXEC). At most one pop per cycle and none outside the WAIT states.
- Supported opcodes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SRA 0x03, SRL 0x02, NOR 0x27.
- EXEC lasts one cycle, giving the ALU a full cycle on stable registered inputs.
  - Supported opcode: result register <= i_alu_result.
  - Unsupported opcode: result register <= ERR_CODE and o_err pulses for one cycle (the cycle after EXEC).
  - Next state is SEND.
- SEND: o_wr_uart = !i_tx_full (Mealy). o_w_data = result register. On the push the FSM goes to WAIT_A. While i_tx_full=1 it holds and does not push.
- Latency: from the opcode pop edge, EXEC is 1 cycle and the push occurs in the next cycle if the TX FIFO is not full, so the push is 2 cycles after the opcode pop.
- Timeout:
  - The counter is active only in WAIT_B and WAIT_OP and clears on every pop and in every other state.
  - When count reaches TIMEOUT_CLKS-1 with no pop in that cycle: state <= WAIT_A and o_timeout pulses for one cycle. The held operands are not cleared, but no byte is sent.
  - A pop in the same cycle as expiry takes priority; the timeout does not fire.
  - Counter width is clog2(TIMEOUT_CLKS).
- No timeout in WAIT_A or SEND. SEND blocks indefinitely on a full TX FIFO.
- o_alu_* change only on pop edges in their own WAIT state. They hold their values through EXEC and SEND.
- Reset asserted mid-frame or mid-SEND: immediate return to the reset values. Any partially received frame is discarded and no push is emitted.

Decomposition:
- Shared package or header: opcode localparams (ADD..NOR), the state encoding, DATA_W and OP_W defaults. The same opcode constants are used by the ALU and the benches.
- Sub-module: uart_alu_watchdog (load-free down/up counter with clear, enable and expire pulse). The FSM, operand registers and opcode-valid decode stay in the top module.

Test Plan:
- Send 0x05, 0x03, 0x20 (ADD) -> three single-cycle o_rd_uart pulses; o_alu_a=0x05, o_alu_b=0x03; one o_wr_uart with o_w_data=0x08, 2 cycles after the opcode pop.
- Send 0x05, 0x07, 0x22 (SUB) -> push 0xFE. Then 0xF0, 0x02, 0x03 (SRA) -> push 0xFC. Back-to-back frames are both answered in order.
- Send 0x01, 0x02, 0x3F -> o_err pulse and push of 0xFF. The next valid frame is processed normally.
- Send 0x11 only, then idle for TIMEOUT_CLKS (bench override 100) -> o_timeout pulse, no push. Then frame 0x0C, 0x0A, 0x24 (AND) -> push 0x08.
- Hold i_tx_full=1 during SEND for 50 cycles -> o_wr_uart=0 and no RX pops. Release -> exactly one push of the correct result.
- Assert i_reset after operand B is popped -> all outputs return to 0. The following full frame 0x03, 0x04, 0x25 (OR) -> push 0x07.
